pk_encode_ctrl: RTL and testbench



---
 rtl/pk_encode_ctrl_if.sv | 27 ++
 rtl/pk_encode_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pk_encode_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pk_encode_ctrl_if.sv
// Output word stream from the public-key encode controller
// to the byte packer (valid/ready, head-of-buffer tags).
interface pk_encode_ctrl_if #(
  parameter int POLY_WORD_WIDTH = 96
);
  logic                       out_valid;
  logic                       out_ready;
  logic [POLY_WORD_WIDTH-1:0] out_data;
  logic                       out_is_rho;
  logic                       out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_is_rho,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_is_rho,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/pk_encode_ctrl.sv
// Streams rho then t1 RAM words to the packer through a
// credit-limited 2-entry buffer with a bypass for in-flight data.
module pk_encode_ctrl #(
  parameter int  K               = 8,
  parameter int  N               = 256,
  parameter int  COEFF_PER_WORD  = 4,
  parameter int  WORD_WIDTH      = 64,
  parameter int  POLY_WORD_WIDTH = 96,
  parameter int  RHO_WORDS       = 4,
  localparam int T1_WORDS        = K * N / COEFF_PER_WORD,
  localparam int T1_ADDR_WIDTH   = $clog2(T1_WORDS),
  localparam int RHO_ADDR_WIDTH  = $clog2(RHO_WORDS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       rho_en,
  output logic [RHO_ADDR_WIDTH-1:0]  rho_addr,
  input  logic [WORD_WIDTH-1:0]      rho_dout,
  output logic                       t1_en,
  output logic [T1_ADDR_WIDTH-1:0]   t1_addr,
  input  logic [POLY_WORD_WIDTH-1:0] t1_dout,
  pk_encode_ctrl_if.master           out
);

  localparam logic [RHO_ADDR_WIDTH-1:0] RHO_LAST =
    RHO_ADDR_WIDTH'(RHO_WORDS - 1);
  localparam logic [T1_ADDR_WIDTH-1:0] T1_LAST =
    T1_ADDR_WIDTH'(T1_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RHO,
    S_T1,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [RHO_ADDR_WIDTH-1:0] rho_cnt_q;
  logic [T1_ADDR_WIDTH-1:0]  t1_cnt_q;

  logic infl_q;
  logic infl_rho_q;
  logic infl_last_q;

  logic [POLY_WORD_WIDTH-1:0] buf_data_q [2];
  logic                       buf_rho_q  [2];
  logic                       buf_last_q [2];
  logic                       rd_ptr_q;
  logic                       wr_ptr_q;
  logic [1:0]                 cnt_q;

  logic                       active;
  logic                       kill;
  logic                       buf_nonempty;
  logic                       valid;
  logic                       pop;
  logic                       pop_buf;
  logic                       push;
  logic [2:0]                 occ_next;
  logic                       credit;
  logic                       last_issue;
  logic [POLY_WORD_WIDTH-1:0] in_data;
  logic [POLY_WORD_WIDTH-1:0] head_data;
  logic                       head_rho;
  logic                       head_last;

  // Credit, handshake and read-issue decode.
  always_comb begin
    active       = (state_q != S_IDLE);
    kill         = abort && active;
    buf_nonempty = (cnt_q != 2'd0);
    valid        = buf_nonempty || infl_q;
    pop          = valid && out.out_ready;
    pop_buf      = pop && buf_nonempty;
    push         = infl_q && !(pop && !buf_nonempty) && !kill;
    occ_next     = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
    credit       = (occ_next < 3'd2);
    rho_en       = (state_q == S_RHO) && credit && !kill;
    t1_en        = (state_q == S_T1) && credit && !kill;
    rho_addr     = rho_cnt_q;
    t1_addr      = t1_cnt_q;
    last_issue   = t1_en && (t1_cnt_q == T1_LAST);
    busy         = active;
  end

  // Head of stream: buffer entry, else the word landing now.
  always_comb begin
    in_data = infl_rho_q ? POLY_WORD_WIDTH'(rho_dout)
                         : t1_dout;
    if (buf_nonempty) begin
      head_data = buf_data_q[rd_ptr_q];
      head_rho  = buf_rho_q[rd_ptr_q];
      head_last = buf_last_q[rd_ptr_q];
    end else begin
      head_data = in_data;
      head_rho  = infl_rho_q;
      head_last = infl_last_q;
    end
    out.out_valid  = valid;
    out.out_data   = valid ? head_data : '0;
    out.out_is_rho = valid && head_rho;
    out.out_last   = valid && head_last;
  end

  // Next-state and done decode; abort overrides everything.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_RHO;
        end
        S_RHO: begin
          if (rho_en && rho_cnt_q == RHO_LAST)
            state_d = S_T1;
        end
        S_T1: begin
          if (last_issue) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (!buf_nonempty && !infl_q) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Read address counters, wrapping back to 0 after the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rho_cnt_q <= '0;
      t1_cnt_q  <= '0;
    end else if (kill) begin
      rho_cnt_q <= '0;
      t1_cnt_q  <= '0;
    end else begin
      if (rho_en) begin
        if (rho_cnt_q == RHO_LAST) rho_cnt_q <= '0;
        else rho_cnt_q <= rho_cnt_q + RHO_ADDR_WIDTH'(1);
      end
      if (t1_en) begin
        if (t1_cnt_q == T1_LAST) t1_cnt_q <= '0;
        else t1_cnt_q <= t1_cnt_q + T1_ADDR_WIDTH'(1);
      end
    end
  end

  // In-flight read tracking; tags travel with the RAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q      <= 1'b0;
      infl_rho_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else if (kill) begin
      infl_q      <= 1'b0;
      infl_rho_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q      <= rho_en || t1_en;
      infl_rho_q  <= rho_en;
      infl_last_q <= last_issue;
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (kill) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (pop_buf) rd_ptr_q <= ~rd_ptr_q;
      if (push)    wr_ptr_q <= ~wr_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop_buf);
    end
  end

  // Buffer storage; contents are masked by valid so need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= in_data;
      buf_rho_q[wr_ptr_q]  <= infl_rho_q;
      buf_last_q[wr_ptr_q] <= infl_last_q;
    end
  end

endmodule

// File: tb/tb_pk_encode_ctrl.sv
// Scoreboard bench for pk_encode_ctrl: directed start/stall/
// abort/reset scenarios against a behavioural RAM model.
module tb_pk_encode_ctrl;

  localparam int PW  = 96;
  localparam int WW  = 64;
  localparam int RAW = 2;
  localparam int TAW = 9;
  localparam int RW  = 4;
  localparam int TW  = 512;
  localparam int NW  = RW + TW;

  typedef struct {
    logic [PW-1:0] d;
    logic          r;
    logic          l;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           abort;
  logic           busy;
  logic           done;
  logic           rho_en;
  logic [RAW-1:0] rho_addr;
  logic [WW-1:0]  rho_dout = '0;
  logic           t1_en;
  logic [TAW-1:0] t1_addr;
  logic [PW-1:0]  t1_dout = '0;

  pk_encode_ctrl_if #(.POLY_WORD_WIDTH(PW)) bus ();

  pk_encode_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .rho_en   (rho_en),
    .rho_addr (rho_addr),
    .rho_dout (rho_dout),
    .t1_en    (t1_en),
    .t1_addr  (t1_addr),
    .t1_dout  (t1_dout),
    .out      (bus.master)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;

  int cyc      = 0;
  int st_cyc   = 0;
  int first_v  = -1;
  int last_cyc = -1;
  int done_cyc = -1;
  int done_cnt = 0;
  int hs       = 0;
  int issued   = 0;
  int max_out  = 0;
  int both_en  = 0;

  function automatic logic [WW-1:0] rho_word(input int i);
    return 64'hA5A5_0000_F00D_0000 + 64'(i) * 64'h0101_0101;
  endfunction

  function automatic logic [PW-1:0] t1_word(input int a);
    return {16'hC0DE, 16'(a), 32'hDEAD_0000 | 32'(a), 32'(a * 3)};
  endfunction

  task automatic chk(input string nm,
                     input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Synchronous RAM models: data one cycle after enable.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rho_en) rho_dout <= rho_word(int'(rho_addr));
    if (t1_en)  t1_dout  <= t1_word(int'(t1_addr));
  end

  // Packer-side ready pattern.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake.
  initial begin : monitor
    exp_t          e;
    int            rel;
    int            outst;
    logic          p_stall = 1'b0;
    logic [PW-1:0] p_data  = '0;
    logic          p_rho   = 1'b0;
    logic          p_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (start && !busy && !rst) begin
        st_cyc   = cyc;
        first_v  = -1;
        last_cyc = -1;
        hs       = 0;
        issued   = 0;
        max_out  = 0;
        both_en  = 0;
      end
      rel = cyc - st_cyc;
      if (rho_en && t1_en) both_en++;
      if (rho_en || t1_en) issued++;
      if (p_stall) begin
        chk("stall_valid", PW'(bus.out_valid), PW'(1));
        chk("stall_data", bus.out_data, p_data);
        chk("stall_rho", PW'(bus.out_is_rho), PW'(p_rho));
        chk("stall_last", PW'(bus.out_last), PW'(p_last));
      end
      if (bus.out_valid && first_v < 0) first_v = rel;
      if (bus.out_valid && bus.out_ready) begin
        hs++;
        if (sb.size() == 0) begin
          chk("extra_word", PW'(1), PW'(0));
        end else begin
          e = sb.pop_front();
          chk("data", bus.out_data, e.d);
          chk("is_rho", PW'(bus.out_is_rho), PW'(e.r));
          chk("last", PW'(bus.out_last), PW'(e.l));
        end
        if (bus.out_last) last_cyc = rel;
      end
      outst = issued - hs;
      if (outst > max_out) max_out = outst;
      if (done) begin
        done_cnt++;
        done_cyc = rel;
        chk("done_sb_empty", PW'(sb.size()), PW'(0));
      end
      p_stall = bus.out_valid && !bus.out_ready &&
                !abort && !rst;
      p_data  = bus.out_data;
      p_rho   = bus.out_is_rho;
      p_last  = bus.out_last;
    end
  end

  task automatic push_seq();
    exp_t e;
    for (int i = 0; i < RW; i++) begin
      e.d = PW'(rho_word(i));
      e.r = 1'b1;
      e.l = 1'b0;
      sb.push_back(e);
    end
    for (int a = 0; a < TW; a++) begin
      e.d = t1_word(a);
      e.r = 1'b0;
      e.l = (a == TW - 1);
      sb.push_back(e);
    end
  endtask

  task automatic run_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    push_seq();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++)
      @(posedge clk);
    #1;
    chk(nm, PW'(done_cnt - d0), PW'(1));
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_ctl"},
        PW'({busy, done, rho_en, t1_en, bus.out_valid,
             bus.out_is_rho, bus.out_last}), PW'(0));
    chk({nm, "_addr"}, PW'({rho_addr, t1_addr}), PW'(0));
    chk({nm, "_data"}, bus.out_data, PW'(0));
  endtask

  task automatic chk_seq(input string nm);
    chk({nm, "_words"}, PW'(hs), PW'(NW));
    chk({nm, "_sb"}, PW'(sb.size()), PW'(0));
    chk({nm, "_credit"}, PW'(max_out <= 2), PW'(1));
    chk({nm, "_onehot"}, PW'(both_en), PW'(0));
  endtask

  initial begin : stim
    int d0;
    int n;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outs("in_reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outs("after_reset");

    // Full-rate stream with timing checks.
    mode = 0;
    run_start();
    wait_done("t_full_done", 700);
    chk("t_full_first", PW'(first_v), PW'(2));
    chk("t_full_lastcyc", PW'(last_cyc), PW'(517));
    chk("t_full_donecyc", PW'(done_cyc), PW'(518));
    chk_seq("t_full");

    // Ready toggling every cycle.
    mode = 1;
    run_start();
    wait_done("t_tog_done", 1600);
    chk_seq("t_tog");

    // Ready held low after start: only two reads.
    mode = 2;
    run_start();
    repeat (50) @(posedge clk);
    #1;
    chk("t_hold_issued", PW'(issued), PW'(2));
    chk("t_hold_rho_en", PW'(rho_en), PW'(0));
    mode = 0;
    wait_done("t_hold_done", 700);
    chk_seq("t_hold");

    // Second start mid-sequence is ignored.
    run_start();
    repeat (98) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    d0 = done_cnt;
    wait_done("t_dbl_done", 700);
    repeat (30) @(posedge clk);
    #1;
    chk("t_dbl_one_done", PW'(done_cnt - d0), PW'(1));
    chk("t_dbl_idle", PW'({busy, bus.out_valid}), PW'(0));
    chk_seq("t_dbl");

    // Abort at t1 address 200.
    run_start();
    n = 0;
    while (!(t1_en && t1_addr == TAW'(200)) && n < 700) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t_abort_reach", PW'(n < 700), PW'(1));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    sb.delete();
    chk("t_abort_busy", PW'(busy), PW'(0));
    chk("t_abort_valid", PW'(bus.out_valid), PW'(0));
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("t_abort_nodone", PW'(done_cnt - d0), PW'(0));
    run_start();
    wait_done("t_abort_re_done", 700);
    chk_seq("t_abort_re");

    // Asynchronous reset in the middle of t1.
    run_start();
    repeat (300) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_idle_outs("t_rst_mid");
    sb.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t_rst_nodone", PW'(done_cnt - d0), PW'(0));
    run_start();
    wait_done("t_rst_re_done", 700);
    chk("t_rst_re_first", PW'(first_v), PW'(2));
    chk_seq("t_rst_re");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
